// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared types and constants for the obstacle scheduler
package dino_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    WAIT     = 3'd2,
    SPAWN    = 3'd3,
    COOLDOWN = 3'd4
  } sched_state_t;

  localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;

  typedef enum logic [1:0] {
    CACTUS_S = 2'd0,
    CACTUS_L = 2'd1,
    BIRD_LO  = 2'd2,
    BIRD_HI  = 2'd3
  } obstacle_t;

  // Fibonacci taps 8,6,5,4 shifted in at the bottom
  function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// rtl/obstacle_scheduler_if.sv - load/count link between scheduler and down_count
interface obstacle_scheduler_if;
  logic       load_en;
  logic [1:0] load_value;
  logic [8:0] count_in;

  modport master (output load_en, output load_value, input count_in);
  modport slave  (input load_en, input load_value, output count_in);
endinterface

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR with seed load on reset
module lfsr8
  import dino_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  // An all-zero state would lock up, so a zero seed is promoted to 1
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= (seed == 8'h00) ? 8'h01 : seed;
    end else if (step) begin
      value <= lfsr8_next(value);
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - arms down_count gaps, spawns obstacles, enforces cooldown
module obstacle_scheduler
  import dino_pkg::*;
#(
  parameter logic [7:0]  SEED    = LFSR_DEFAULT_SEED,
  parameter int unsigned MIN_GAP = 4,
  parameter logic [15:0] TIMEOUT = 16'd4095
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        game_tick,
  obstacle_scheduler_if.master        ctr,
  output logic                        spawn,
  output logic [1:0]                  obstacle_type,
  output logic [7:0]                  spawn_count,
  output logic                        timeout_err,
  output logic                        busy
);

  sched_state_t state;
  logic [15:0]  watchdog;
  logic [3:0]   cooldown;
  obstacle_t    pending_type;
  logic [7:0]   lfsr;
  logic         unused_lfsr_bits;

  lfsr8 u_lfsr (
    .clock (clock),
    .reset (reset),
    .step  (state == ARM),
    .seed  (SEED),
    .value (lfsr)
  );

  assign ctr.load_en       = (state == ARM);
  assign ctr.load_value    = (state == ARM) ? lfsr[1:0] : 2'b00;
  assign spawn             = (state == SPAWN);
  assign busy              = (state != IDLE);
  assign unused_lfsr_bits  = ^lfsr[7:4];

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      watchdog      <= 16'd0;
      cooldown      <= 4'd0;
      pending_type  <= CACTUS_S;
      obstacle_type <= 2'b00;
      spawn_count   <= 8'd0;
      timeout_err   <= 1'b0;
    end else begin
      // A SPAWN already in progress completes even if run drops this cycle
      if (state == SPAWN) begin
        obstacle_type <= pending_type;
        if (spawn_count != 8'hFF) begin
          spawn_count <= spawn_count + 8'd1;
        end
      end

      if (!run) begin
        state    <= IDLE;
        watchdog <= 16'd0;
        cooldown <= 4'd0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            pending_type <= obstacle_t'(lfsr[3:2]);
            watchdog     <= 16'd0;
            state        <= WAIT;
          end
          WAIT: begin
            watchdog <= watchdog + 16'd1;
            // Counter expiry wins over the watchdog when both happen together
            if (ctr.count_in == 9'd0) begin
              state <= SPAWN;
            end else if (watchdog + 16'd1 == TIMEOUT) begin
              state       <= SPAWN;
              timeout_err <= 1'b1;
            end
          end
          SPAWN: begin
            watchdog <= 16'd0;
            cooldown <= 4'd0;
            state    <= COOLDOWN;
          end
          COOLDOWN: begin
            if (game_tick) begin
              if (cooldown == 4'(MIN_GAP - 1)) begin
                cooldown <= 4'd0;
                state    <= ARM;
              end else begin
                cooldown <= cooldown + 4'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - directed scoreboard bench for obstacle_scheduler
module tb_obstacle_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic game_tick = 1'b0;

  logic       spawn, timeout_err, busy;
  logic [1:0] obstacle_type;
  logic [7:0] spawn_count;
  logic       spawn0, timeout_err0, busy0;
  logic [1:0] obstacle_type0;
  logic [7:0] spawn_count0;

  obstacle_scheduler_if ctr ();
  obstacle_scheduler_if ctr0 ();

  obstacle_scheduler #(.SEED(8'hA5), .MIN_GAP(4), .TIMEOUT(16'd16)) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .game_tick     (game_tick),
    .ctr           (ctr),
    .spawn         (spawn),
    .obstacle_type (obstacle_type),
    .spawn_count   (spawn_count),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  obstacle_scheduler #(.SEED(8'h00)) dut0 (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .game_tick     (game_tick),
    .ctr           (ctr0),
    .spawn         (spawn0),
    .obstacle_type (obstacle_type0),
    .spawn_count   (spawn_count0),
    .timeout_err   (timeout_err0),
    .busy          (busy0)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] m_lfsr = 8'hA5;
  logic [7:0] m_count = 8'd0;
  logic [1:0] type_q[$];

  function automatic logic [7:0] model_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_for_arm(input int budget);
    int n = 0;
    while (ctr.load_en !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("arm_seen", 32'(ctr.load_en), 32'h1);
    if (ctr.load_en === 1'b1) begin
      check("load_value", 32'(ctr.load_value), 32'(m_lfsr[1:0]));
      type_q.push_back(m_lfsr[3:2]);
      m_lfsr = model_next(m_lfsr);
      step();
      check("load_en_single_cycle", 32'(ctr.load_en), 32'h0);
      check("lfsr_after_arm", 32'(dut.lfsr), 32'(m_lfsr));
    end
  endtask

  task automatic spawn_result();
    logic [1:0] t;
    t = 2'b00;
    check("sb_depth", 32'(type_q.size()), 32'h1);
    if (type_q.size() > 0) t = type_q.pop_front();
    m_count = (m_count == 8'hFF) ? 8'hFF : m_count + 8'd1;
    step();
    check("spawn_one_cycle", 32'(spawn), 32'h0);
    check("obstacle_type", 32'(obstacle_type), 32'(t));
    check("spawn_count", 32'(spawn_count), 32'(m_count));
  endtask

  task automatic wait_for_spawn(input int budget);
    int n = 0;
    while (spawn !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("spawn_seen", 32'(spawn), 32'h1);
    if (spawn === 1'b1) spawn_result();
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    ctr.count_in  = 9'd7;
    ctr0.count_in = 9'd7;
    step();
    step();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_load_en", 32'(ctr.load_en), 32'h0);
    check("rst_load_value", 32'(ctr.load_value), 32'h0);
    check("rst_spawn", 32'(spawn), 32'h0);
    check("rst_obstacle_type", 32'(obstacle_type), 32'h0);
    check("rst_spawn_count", 32'(spawn_count), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    check("rst_lfsr", 32'(dut.lfsr), 32'hA5);
    check("rst_lfsr_seed0", 32'(dut0.lfsr), 32'h01);

    // cycle 0: run rises
    reset = 1'b0;
    run   = 1'b1;
    step();
    check("seed0_load_en", 32'(ctr0.load_en), 32'h1);
    check("seed0_load_value", 32'(ctr0.load_value), 32'h1);
    wait_for_arm(0);
    check("lfsr_4a", 32'(dut.lfsr), 32'h4A);
    check("seed0_lfsr", 32'(dut0.lfsr), 32'h02);
    ctr0.count_in = 9'd0;
    step();
    check("seed0_spawn", 32'(spawn0), 32'h1);
    ctr0.count_in = 9'd7;
    step();
    check("seed0_type", 32'(obstacle_type0), 32'h0);
    check("seed0_count", 32'(spawn_count0), 32'h1);
    step();
    check("wait_no_spawn", 32'(spawn), 32'h0);
    check("wait_busy", 32'(busy), 32'h1);
    ctr.count_in = 9'd0;
    wait_for_spawn(1);
    check("first_type", 32'(obstacle_type), 32'h1);
    ctr.count_in = 9'd7;

    // cooldown: ticks every 3 cycles, ARM one cycle after the 4th
    for (int k = 0; k < 4; k++) begin
      step();
      step();
      check("cooldown_no_arm", 32'(ctr.load_en), 32'h0);
      game_tick = 1'b1;
      step();
      game_tick = 1'b0;
      if (k < 3) check("cooldown_no_arm_tick", 32'(ctr.load_en), 32'h0);
    end
    check("second_load_value", 32'(ctr.load_value), 32'h2);
    wait_for_arm(0);

    // run drops in WAIT as the counter expires
    run          = 1'b0;
    ctr.count_in = 9'd0;
    step();
    check("abort_spawn", 32'(spawn), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_count", 32'(spawn_count), 32'(m_count));
    if (type_q.size() > 0) void'(type_q.pop_front());
    run          = 1'b1;
    ctr.count_in = 9'd7;
    step();
    check("pre_timeout_err", 32'(timeout_err), 32'h0);
    wait_for_arm(0);

    // watchdog: 16 WAIT cycles then a forced spawn
    n = 1;
    while (spawn !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("timeout_wait_cycles", 32'(n), 32'd17);
    check("timeout_spawn", 32'(spawn), 32'h1);
    check("timeout_err_set", 32'(timeout_err), 32'h1);
    if (spawn === 1'b1) spawn_result();

    game_tick    = 1'b1;
    ctr.count_in = 9'd0;
    for (int i = 0; i < 3; i++) begin
      wait_for_arm(10);
      wait_for_spawn(3);
      check("timeout_err_sticky", 32'(timeout_err), 32'h1);
    end
    for (int i = 0; i < 255; i++) begin
      wait_for_arm(10);
      wait_for_spawn(3);
    end
    check("spawn_count_saturated", 32'(spawn_count), 32'd255);

    // reset in the middle of WAIT
    ctr.count_in = 9'd7;
    wait_for_arm(10);
    check("mid_wait_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    step();
    check("rst2_busy", 32'(busy), 32'h0);
    check("rst2_load_en", 32'(ctr.load_en), 32'h0);
    check("rst2_spawn", 32'(spawn), 32'h0);
    check("rst2_obstacle_type", 32'(obstacle_type), 32'h0);
    check("rst2_spawn_count", 32'(spawn_count), 32'h0);
    check("rst2_timeout_err", 32'(timeout_err), 32'h0);
    check("rst2_lfsr", 32'(dut.lfsr), 32'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
